// File: rtl/mmu_rd_arbiter.sv
// Multi-channel read arbiter with an in-order ID FIFO that routes
// downstream responses back to the requesting channel.
module mmu_rd_arbiter #(
    parameter int CH     = 2,
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4,
    parameter int RR     = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CH-1:0]        REQ_RDEN,
    input  logic [CH*AWIDTH-1:0] REQ_RADDR,
    output logic [CH-1:0]        REQ_GRANT,
    output logic [CH-1:0]        RSP_RVALID,
    output logic [DWIDTH-1:0]    RSP_RDATA,
    output logic                 MEM_WAIT,
    output logic                 ERR,
    output logic                 M_RDEN,
    output logic [AWIDTH-1:0]    M_RADDR,
    input  logic                 M_RREADY,
    input  logic                 M_RVALID,
    input  logic [DWIDTH-1:0]    M_RDATA
);

    localparam int IDW = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [IDW-1:0] LAST_RST = IDW'(CH - 1);

    logic [CW-1:0]  count;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [IDW-1:0] id_mem [DEPTH];
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] head_id;
    logic           found;
    logic           grant_ok;
    logic           push;
    logic           pop;
    int             idx;

    assign MEM_WAIT = (count == CW'(DEPTH));
    // The issue slot is usable when empty or being drained this cycle.
    assign grant_ok = !MEM_WAIT && (!M_RDEN || M_RREADY);

    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int k = 0; k < CH; k++) begin
            if (RR != 0) begin
                idx = (int'(last_grant) + 1 + k) % CH;
            end else begin
                idx = k;
            end
            if (!found && REQ_RDEN[idx[IDW-1:0]]) begin
                found    = 1'b1;
                grant_id = idx[IDW-1:0];
            end
        end
    end

    assign push      = grant_ok && found;
    assign pop       = M_RVALID && (count != '0);
    assign head_id   = id_mem[rd_ptr];
    assign REQ_GRANT = push ? (CH'(1) << grant_id) : '0;

    always_ff @(posedge CLK) begin
        if (push) begin
            id_mem[wr_ptr] <= grant_id;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            M_RDEN     <= 1'b0;
            M_RADDR    <= '0;
            RSP_RVALID <= '0;
            RSP_RDATA  <= '0;
            ERR        <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_grant <= LAST_RST;
        end else begin
            if (push) begin
                M_RDEN     <= 1'b1;
                M_RADDR    <= REQ_RADDR[int'(grant_id)*AWIDTH +: AWIDTH];
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= grant_id;
            end else if (M_RREADY) begin
                M_RDEN <= 1'b0;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                RSP_RVALID <= CH'(1) << head_id;
                RSP_RDATA  <= M_RDATA;
            end else begin
                RSP_RVALID <= '0;
            end
            // A response with nothing outstanding is dropped and flagged.
            if (M_RVALID && (count == '0)) begin
                ERR <= 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_mmu_rd_arbiter.sv
// Directed and randomized bench for mmu_rd_arbiter against a
// queue-based reference model.
module tb_mmu_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [63:0] raddr;
    logic        m_rready;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    logic [1:0]  grant, rsp_v;
    logic [31:0] rsp_d, m_raddr;
    logic        mem_wait, err, m_rden;

    logic [1:0]  grant0, rsp_v0;
    logic [31:0] rsp_d0, m_raddr0;
    logic        mem_wait0, err0, m_rden0;

    int passed = 0;
    int total  = 0;

    int          q[$];
    bit          mrden;
    logic [31:0] maddr;
    int          last;
    bit          merr;
    logic [1:0]  mrspv;
    logic [31:0] mrspd;
    int          gsel;

    logic [1:0] exp_rr [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    always #5 clk = ~clk;

    mmu_rd_arbiter #(
        .CH(2), .AWIDTH(32), .DWIDTH(32), .DEPTH(4), .RR(1)
    ) dut (
        .CLK(clk), .RST(rst),
        .REQ_RDEN(req), .REQ_RADDR(raddr),
        .REQ_GRANT(grant), .RSP_RVALID(rsp_v), .RSP_RDATA(rsp_d),
        .MEM_WAIT(mem_wait), .ERR(err),
        .M_RDEN(m_rden), .M_RADDR(m_raddr),
        .M_RREADY(m_rready), .M_RVALID(m_rvalid), .M_RDATA(m_rdata)
    );

    mmu_rd_arbiter #(
        .CH(2), .AWIDTH(32), .DWIDTH(32), .DEPTH(4), .RR(0)
    ) dut0 (
        .CLK(clk), .RST(rst),
        .REQ_RDEN(req), .REQ_RADDR(raddr),
        .REQ_GRANT(grant0), .RSP_RVALID(rsp_v0), .RSP_RDATA(rsp_d0),
        .MEM_WAIT(mem_wait0), .ERR(err0),
        .M_RDEN(m_rden0), .M_RADDR(m_raddr0),
        .M_RREADY(m_rready), .M_RVALID(m_rvalid), .M_RDATA(m_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        mrden = 1'b0;
        maddr = '0;
        last  = 1;
        merr  = 1'b0;
        mrspv = '0;
        mrspd = '0;
        gsel  = -1;
    endtask

    task automatic sample();
        int c;
        #4;
        gsel = -1;
        if (q.size() < 4 && (!mrden || m_rready)) begin
            for (int k = 1; k <= 2; k++) begin
                c = (last + k) % 2;
                if (gsel < 0 && ((req >> c) & 2'd1) != 2'd0) gsel = c;
            end
        end
        chk("grant", grant, (gsel < 0) ? 0 : (1 << gsel));
        chk("m_rden", m_rden, mrden);
        chk("m_raddr", m_raddr, maddr);
        chk("rsp_rvalid", rsp_v, mrspv);
        chk("rsp_rdata", rsp_d, mrspd);
        chk("mem_wait", mem_wait, q.size() == 4);
        chk("err", err, merr);
    endtask

    task automatic advance();
        int sz;
        sz = q.size();
        mrspv = '0;
        if (m_rvalid) begin
            if (sz > 0) begin
                mrspv = 2'(1 << q[0]);
                mrspd = m_rdata;
                void'(q.pop_front());
            end else begin
                merr = 1'b1;
            end
        end
        if (gsel >= 0) begin
            q.push_back(gsel);
            mrden = 1'b1;
            maddr = raddr[gsel*32 +: 32];
            last  = gsel;
        end else if (m_rready) begin
            mrden = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_m_rden", m_rden, 0);
        chk("rst_m_raddr", m_raddr, 0);
        chk("rst_rsp_rvalid", rsp_v, 0);
        chk("rst_rsp_rdata", rsp_d, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_wait", mem_wait, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        raddr    = '0;
        m_rready = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // single read
        req = 2'b01;
        raddr[31:0] = 32'h100;
        m_rready = 1'b1;
        sample();
        chk("t1_grant", grant, 2'b01);
        advance();
        req = 2'b00;
        sample();
        chk("t1_m_rden", m_rden, 1);
        chk("t1_m_raddr", m_raddr, 32'h100);
        advance();
        m_rvalid = 1'b1;
        m_rdata  = 32'hDEAD;
        tick();
        m_rvalid = 1'b0;
        sample();
        chk("t1_rsp_rvalid", rsp_v, 2'b01);
        chk("t1_rsp_rdata", rsp_d, 32'hDEAD);
        advance();

        // round-robin vs fixed priority, then full
        do_reset();
        req   = 2'b11;
        raddr = {32'h2000, 32'h1000};
        m_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("rr_grant", grant, exp_rr[i]);
            chk("fp_grant", grant0, 2'b01);
            advance();
        end
        sample();
        chk("full_wait", mem_wait, 1);
        chk("full_nogrant", grant, 0);
        chk("fp_full_wait", mem_wait0, 1);
        advance();
        m_rvalid = 1'b1;
        m_rdata  = 32'hA0;
        sample();
        chk("no_bypass", grant, 0);
        advance();
        m_rvalid = 1'b0;
        sample();
        chk("wait_clear", mem_wait, 0);
        chk("resume_grant", grant, 2'b01);
        advance();
        req = 2'b00;
        m_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_rdata = 32'hB0 + 32'(i);
            tick();
        end
        m_rvalid = 1'b0;
        tick();

        // response ordering
        do_reset();
        req = 2'b11;
        m_rready = 1'b1;
        tick();
        tick();
        tick();
        req = 2'b00;
        m_rvalid = 1'b1;
        m_rdata  = 32'hA;
        tick();
        m_rdata = 32'hB;
        sample();
        chk("ord1_v", rsp_v, 2'b01);
        chk("ord1_d", rsp_d, 32'hA);
        advance();
        m_rdata = 32'hC;
        sample();
        chk("ord2_v", rsp_v, 2'b10);
        chk("ord2_d", rsp_d, 32'hB);
        advance();
        m_rvalid = 1'b0;
        sample();
        chk("ord3_v", rsp_v, 2'b01);
        chk("ord3_d", rsp_d, 32'hC);
        advance();

        // backpressure
        req = 2'b01;
        raddr[31:0] = 32'h300;
        m_rready = 1'b0;
        sample();
        chk("bp_grant", grant, 2'b01);
        advance();
        req = 2'b10;
        raddr[63:32] = 32'h400;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("bp_addr", m_raddr, 32'h300);
            chk("bp_nogrant", grant, 0);
            advance();
        end
        m_rready = 1'b1;
        sample();
        chk("bp_accept_grant", grant, 2'b10);
        advance();
        req = 2'b00;
        sample();
        chk("bp_addr2", m_raddr, 32'h400);
        advance();

        // drain, then a spurious response
        m_rvalid = 1'b1;
        tick();
        tick();
        tick();
        m_rvalid = 1'b0;
        sample();
        chk("spur_err", err, 1);
        chk("spur_no_rvalid", rsp_v, 0);
        advance();

        // reset with reads in flight
        req = 2'b11;
        tick();
        tick();
        tick();
        req = 2'b00;
        tick();
        do_reset();
        req = 2'b01;
        raddr[31:0] = 32'h500;
        sample();
        chk("post_rst_grant", grant, 2'b01);
        advance();
        req = 2'b00;
        tick();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (((req >> c) & 2'd1) == 2'd0 && $urandom_range(2) == 0) begin
                    req = req | 2'(1 << c);
                    raddr[c*32 +: 32] = $urandom;
                end
            end
            m_rready = ($urandom_range(3) != 0);
            m_rvalid = (q.size() > 0) && ($urandom_range(1) == 1);
            m_rdata  = $urandom;
            tick();
            if (gsel >= 0) req = req & ~(2'(1 << gsel));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mmu_rd_arbiter.md
MMU_RD_ARBITER -- requirements
Module: mmu_rd_arbiter

Interface
REQ-001 SHALL have parameter CH, default 2, number of requester channels (1..8).
REQ-002 SHALL have parameter AWIDTH, default 32, address width.
REQ-003 SHALL have parameter DWIDTH, default 32, data width.
REQ-004 SHALL have parameter DEPTH, default 4, maximum outstanding reads (power of two, >=2).
REQ-005 SHALL have parameter RR, default 1; 1 = round-robin, 0 = fixed priority (channel 0 highest).
REQ-006 SHALL have one clock; reset is asynchronous and active-high: ports CLK and RST.
REQ-007 CLK  in  1  clock.
REQ-008 RST  in  1  asynchronous active-high reset.
REQ-009 REQ_RDEN  in  CH  per-channel read request, held until granted.
REQ-010 REQ_RADDR  in  CH*AWIDTH  channel i address at [i*AWIDTH +: AWIDTH].
REQ-011 REQ_GRANT  out  CH  one-hot, combinational; request accepted this cycle.
REQ-012 RSP_RVALID  out  CH  one-hot response strobe, registered.
REQ-013 RSP_RDATA  out  DWIDTH  response data, shared by all channels, registered.
REQ-014 MEM_WAIT  out  1  outstanding count equals DEPTH.
REQ-015 ERR  out  1  sticky spurious-response flag.
REQ-016 M_RDEN  out  1  downstream read request, registered.
REQ-017 M_RADDR  out  AWIDTH  downstream read address, registered.
REQ-018 M_RREADY  in  1  downstream accepts M_RDEN/M_RADDR this cycle.
REQ-019 M_RVALID  in  1  downstream response valid (in issue order).
REQ-020 M_RDATA  in  DWIDTH  downstream response data.

Function
REQ-021 Grant possible in a cycle only if count < DEPTH and issue register free (M_RDEN=0) or being accepted (M_RDEN & M_RREADY).
REQ-022 RR=0: lowest-index requesting channel granted.
REQ-023 RR=1: search starts at (last_grant+1) mod CH, wraps; last_grant updates only on a grant; reset value CH-1 (channel 0 first).
REQ-024 On grant of channel i: next cycle M_RDEN=1, M_RADDR=address of i; i pushed to ID FIFO; count+1.
REQ-025 M_RDEN/M_RADDR held stable until M_RREADY; M_RDEN cleared after acceptance unless a new grant loads it same edge (back-to-back, 1 issue/cycle).
REQ-026 M_RVALID with count>0: pop FIFO head id h; next cycle RSP_RVALID[h]=1, RSP_RDATA=M_RDATA; count-1; latency exactly 1 cycle.
REQ-027 Simultaneous grant and response: push and pop both occur, count unchanged.
REQ-028 Grant never issued at count=DEPTH, even if a response pops that cycle (no full bypass).
REQ-029 FIFO read/write pointers wrap mod DEPTH; count width clog2(DEPTH)+1.
REQ-030 M_RVALID with count=0: data discarded, no RSP_RVALID, ERR set until reset.
REQ-031 RSP_RVALID cleared in any cycle without a valid pop; RSP_RDATA holds last value.
REQ-032 MEM_WAIT = (count==DEPTH), combinational from registered count.

Reset
REQ-033 RST=1 asynchronously clears: M_RDEN=0, M_RADDR=0, RSP_RVALID=0, RSP_RDATA=0, ERR=0, count=0, FIFO pointers=0, last_grant=CH-1.
REQ-034 Reset mid-operation discards all in-flight state; downstream is reset by the same RST; responses arriving afterwards with count=0 follow REQ-030.

Verification (CH=2, DEPTH=4, RR=1)
REQ-035 Single read: REQ_RDEN=01, addr0=0x100, M_RREADY=1, M_RVALID 2 cycles later with 0xDEAD -> GRANT=01 cycle 0, M_RDEN/M_RADDR=0x100 cycle 1, RSP_RVALID=01, RSP_RDATA=0xDEAD one cycle after M_RVALID.
REQ-036 Round-robin: both channels requesting continuously, M_RREADY=1 -> grants alternate 01,10,01,10; RR=0 rerun -> grants 01 only.
REQ-037 Full: M_RVALID held 0, 4 grants -> MEM_WAIT=1, no 5th grant; one M_RVALID -> MEM_WAIT=0 next cycle, grant resumes.
REQ-038 Ordering: grants ch0,ch1,ch0 then responses 0xA,0xB,0xC -> RSP_RVALID 01/0xA, 10/0xB, 01/0xC.
REQ-039 Backpressure and spurious: M_RREADY=0 for 3 cycles -> M_RADDR stable, no new grant beyond count; M_RVALID with count=0 -> ERR=1, no RSP_RVALID.
REQ-040 Reset mid-operation: RST pulse with 3 outstanding -> all outputs at reset values immediately, MEM_WAIT=0, next request granted normally.
